// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared core widths and named architectural register indices
package cpu_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 4;

    localparam logic [3:0] REG_ZERO = 4'd0;
    localparam logic [3:0] REG_SP   = 4'd13;
    localparam logic [3:0] REG_LR   = 4'd14;
    localparam logic [3:0] REG_PC   = 4'd15;

endpackage

// File: rtl/rf_read_port.sv
// rtl/rf_read_port.sv - one combinational register file read port with R0 and write-back bypass
module rf_read_port #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_REGS   = 16
) (
    input  logic                                 clear,
    input  logic [ADDR_WIDTH-1:0]                rd_addr,
    input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  regs_in,
    input  logic                                 wb_commit,
    input  logic [ADDR_WIDTH-1:0]                wb_addr,
    input  logic [DATA_WIDTH-1:0]                wb_data,
    output logic [DATA_WIDTH-1:0]                rd_data
);
    import cpu_pkg::*;

    always_comb begin
        rd_data = '0;
        if (clear || rd_addr == REG_ZERO) begin
            rd_data = '0;
        end else if (wb_commit && wb_addr == rd_addr) begin
            rd_data = wb_data;
        end else begin
            rd_data = regs_in[rd_addr];
        end
    end

endmodule

// File: rtl/register_file.sv
// rtl/register_file.sv - architectural register file, one write port, three bypassed read ports
module register_file #(
    parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = cpu_pkg::ADDR_WIDTH,
    parameter int NUM_REGS   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  reg_write_en_in_wb,
    input  logic [ADDR_WIDTH-1:0] write_reg_addr_in_wb,
    input  logic [DATA_WIDTH-1:0] write_data_in_wb,
    input  logic [ADDR_WIDTH-1:0] read_addr1_in_id,
    input  logic [ADDR_WIDTH-1:0] read_addr2_in_id,
    input  logic [ADDR_WIDTH-1:0] read_addr3_in_id,
    output logic [DATA_WIDTH-1:0] read_data1_out_id,
    output logic [DATA_WIDTH-1:0] read_data2_out_id,
    output logic [DATA_WIDTH-1:0] read_data3_out_id,
    output logic [15:0]           write_count_out
);
    import cpu_pkg::*;

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
    logic [15:0]                         write_count_q, write_count_d;
    logic                                commit;
    logic                                bypass_ok;

    assign commit    = enable && reg_write_en_in_wb && (write_reg_addr_in_wb != REG_ZERO);
    // Reset also masks the bypass so reads stay zero for its whole duration.
    assign bypass_ok = commit && !reset;

    always_comb begin
        regs_d        = regs_q;
        write_count_d = write_count_q;
        if (commit) begin
            regs_d[write_reg_addr_in_wb] = write_data_in_wb;
            write_count_d                = write_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q        <= '0;
            write_count_q <= '0;
        end else begin
            regs_q        <= regs_d;
            write_count_q <= write_count_d;
        end
    end

    assign write_count_out = write_count_q;

    rf_read_port #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .NUM_REGS(NUM_REGS)) u_port1 (
        .clear(reset), .rd_addr(read_addr1_in_id), .regs_in(regs_q), .wb_commit(bypass_ok),
        .wb_addr(write_reg_addr_in_wb), .wb_data(write_data_in_wb), .rd_data(read_data1_out_id)
    );

    rf_read_port #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .NUM_REGS(NUM_REGS)) u_port2 (
        .clear(reset), .rd_addr(read_addr2_in_id), .regs_in(regs_q), .wb_commit(bypass_ok),
        .wb_addr(write_reg_addr_in_wb), .wb_data(write_data_in_wb), .rd_data(read_data2_out_id)
    );

    rf_read_port #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .NUM_REGS(NUM_REGS)) u_port3 (
        .clear(reset), .rd_addr(read_addr3_in_id), .regs_in(regs_q), .wb_commit(bypass_ok),
        .wb_addr(write_reg_addr_in_wb), .wb_data(write_data_in_wb), .rd_data(read_data3_out_id)
    );

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - directed self-checking bench for register_file
module tb_register_file;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        reg_write_en_in_wb;
    logic [3:0]  write_reg_addr_in_wb;
    logic [31:0] write_data_in_wb;
    logic [3:0]  read_addr1_in_id, read_addr2_in_id, read_addr3_in_id;
    logic [31:0] read_data1_out_id, read_data2_out_id, read_data3_out_id;
    logic [15:0] write_count_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    register_file dut (
        .clk(clk), .reset(reset), .enable(enable),
        .reg_write_en_in_wb(reg_write_en_in_wb),
        .write_reg_addr_in_wb(write_reg_addr_in_wb),
        .write_data_in_wb(write_data_in_wb),
        .read_addr1_in_id(read_addr1_in_id),
        .read_addr2_in_id(read_addr2_in_id),
        .read_addr3_in_id(read_addr3_in_id),
        .read_data1_out_id(read_data1_out_id),
        .read_data2_out_id(read_data2_out_id),
        .read_data3_out_id(read_data3_out_id),
        .write_count_out(write_count_out)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; reg_write_en_in_wb = 1'b0;
        write_reg_addr_in_wb = 4'd0; write_data_in_wb = 32'd0;
        read_addr1_in_id = 4'd1; read_addr2_in_id = 4'd7; read_addr3_in_id = 4'd15;
        step();
        step();
        checks++; if (read_data1_out_id !== 32'd0) begin errors++; $display("FAIL reset_rd1 got %h exp %h", read_data1_out_id, 32'd0); end
        checks++; if (read_data2_out_id !== 32'd0) begin errors++; $display("FAIL reset_rd2 got %h exp %h", read_data2_out_id, 32'd0); end
        checks++; if (read_data3_out_id !== 32'd0) begin errors++; $display("FAIL reset_rd3 got %h exp %h", read_data3_out_id, 32'd0); end
        checks++; if (write_count_out !== 16'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", write_count_out); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_write_read();
        @(negedge clk);
        reg_write_en_in_wb = 1'b1; write_reg_addr_in_wb = 4'd1; write_data_in_wb = 32'd100;
        read_addr1_in_id = 4'd5;
        step();
        reg_write_en_in_wb = 1'b0; read_addr1_in_id = 4'd1;
        #1;
        checks++; if (read_data1_out_id !== 32'd100) begin errors++; $display("FAIL write_read_r1 got %h exp %h", read_data1_out_id, 32'd100); end
        checks++; if (write_count_out !== 16'd1) begin errors++; $display("FAIL write_read_count got %0d exp 1", write_count_out); end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        reg_write_en_in_wb = 1'b1; write_reg_addr_in_wb = 4'd2; write_data_in_wb = 32'hFACEB00C;
        read_addr2_in_id = 4'd2; read_addr3_in_id = 4'd2;
        #1;
        checks++; if (read_data2_out_id !== 32'hFACEB00C) begin errors++; $display("FAIL bypass_rd2_pre got %h exp %h", read_data2_out_id, 32'hFACEB00C); end
        checks++; if (read_data3_out_id !== 32'hFACEB00C) begin errors++; $display("FAIL bypass_rd3_pre got %h exp %h", read_data3_out_id, 32'hFACEB00C); end
        checks++; if (write_count_out !== 16'd1) begin errors++; $display("FAIL bypass_count_pre got %0d exp 1", write_count_out); end
        step();
        reg_write_en_in_wb = 1'b0; write_data_in_wb = 32'h0;
        #1;
        checks++; if (read_data2_out_id !== 32'hFACEB00C) begin errors++; $display("FAIL bypass_rd2_post got %h exp %h", read_data2_out_id, 32'hFACEB00C); end
        checks++; if (read_data3_out_id !== 32'hFACEB00C) begin errors++; $display("FAIL bypass_rd3_post got %h exp %h", read_data3_out_id, 32'hFACEB00C); end
        checks++; if (write_count_out !== 16'd2) begin errors++; $display("FAIL bypass_count_post got %0d exp 2", write_count_out); end
    endtask

    task automatic test_r0();
        @(negedge clk);
        reg_write_en_in_wb = 1'b1; write_reg_addr_in_wb = 4'd0; write_data_in_wb = 32'h11223344;
        read_addr1_in_id = 4'd0;
        #1;
        checks++; if (read_data1_out_id !== 32'd0) begin errors++; $display("FAIL r0_during got %h exp 0", read_data1_out_id); end
        step();
        reg_write_en_in_wb = 1'b0;
        #1;
        checks++; if (read_data1_out_id !== 32'd0) begin errors++; $display("FAIL r0_after got %h exp 0", read_data1_out_id); end
        checks++; if (write_count_out !== 16'd2) begin errors++; $display("FAIL r0_count got %0d exp 2", write_count_out); end
    endtask

    task automatic test_disable();
        @(negedge clk);
        enable = 1'b1; reg_write_en_in_wb = 1'b0; write_reg_addr_in_wb = 4'd3; write_data_in_wb = 32'd50;
        read_addr1_in_id = 4'd3;
        #1;
        checks++; if (read_data1_out_id !== 32'd0) begin errors++; $display("FAIL wen0_bypass got %h exp 0", read_data1_out_id); end
        step();
        checks++; if (read_data1_out_id !== 32'd0) begin errors++; $display("FAIL wen0_hold got %h exp 0", read_data1_out_id); end
        @(negedge clk);
        enable = 1'b0; reg_write_en_in_wb = 1'b1;
        #1;
        checks++; if (read_data1_out_id !== 32'd0) begin errors++; $display("FAIL stall_bypass got %h exp 0", read_data1_out_id); end
        step();
        checks++; if (read_data1_out_id !== 32'd0) begin errors++; $display("FAIL stall_hold got %h exp 0", read_data1_out_id); end
        checks++; if (write_count_out !== 16'd2) begin errors++; $display("FAIL stall_count got %0d exp 2", write_count_out); end
        enable = 1'b1; reg_write_en_in_wb = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        reg_write_en_in_wb = 1'b1; write_reg_addr_in_wb = 4'd1; write_data_in_wb = 32'h11223344;
        step();
        read_addr1_in_id = 4'd1; read_addr2_in_id = 4'd1; read_addr3_in_id = 4'd1;
        #1;
        checks++; if (read_data1_out_id !== 32'h11223344) begin errors++; $display("FAIL mid_pre_r1 got %h exp %h", read_data1_out_id, 32'h11223344); end
        write_data_in_wb = 32'hDEADBEEF;
        reset = 1'b1;
        #1;
        checks++; if (read_data1_out_id !== 32'd0) begin errors++; $display("FAIL mid_rd1 got %h exp 0", read_data1_out_id); end
        checks++; if (read_data2_out_id !== 32'd0) begin errors++; $display("FAIL mid_rd2 got %h exp 0", read_data2_out_id); end
        checks++; if (read_data3_out_id !== 32'd0) begin errors++; $display("FAIL mid_rd3 got %h exp 0", read_data3_out_id); end
        checks++; if (write_count_out !== 16'd0) begin errors++; $display("FAIL mid_count got %0d exp 0", write_count_out); end
        step();
        @(negedge clk);
        reg_write_en_in_wb = 1'b0;
        reset = 1'b0;
        #1;
        checks++; if (read_data1_out_id !== 32'd0) begin errors++; $display("FAIL mid_lost_write got %h exp 0", read_data1_out_id); end
        checks++; if (write_count_out !== 16'd0) begin errors++; $display("FAIL mid_count_after got %0d exp 0", write_count_out); end
    endtask

    task automatic test_sweep();
        logic [31:0] exp;
        for (int k = 1; k < 16; k++) begin
            @(negedge clk);
            reg_write_en_in_wb = 1'b1; write_reg_addr_in_wb = 4'(k); write_data_in_wb = 32'(k) * 32'h01010101;
        end
        step();
        reg_write_en_in_wb = 1'b0; write_reg_addr_in_wb = 4'd0; write_data_in_wb = 32'd0;
        for (int k = 0; k < 16; k++) begin
            read_addr1_in_id = 4'(k); read_addr2_in_id = 4'(k); read_addr3_in_id = 4'(15 - k);
            #1;
            exp = 32'(k) * 32'h01010101;
            checks++; if (read_data1_out_id !== exp) begin errors++; $display("FAIL sweep_rd1_r%0d got %h exp %h", k, read_data1_out_id, exp); end
            checks++; if (read_data2_out_id !== exp) begin errors++; $display("FAIL sweep_rd2_r%0d got %h exp %h", k, read_data2_out_id, exp); end
            exp = 32'(15 - k) * 32'h01010101;
            checks++; if (read_data3_out_id !== exp) begin errors++; $display("FAIL sweep_rd3_r%0d got %h exp %h", 15 - k, read_data3_out_id, exp); end
        end
        checks++; if (write_count_out !== 16'd15) begin errors++; $display("FAIL sweep_count got %0d exp 15", write_count_out); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_r0();
        test_disable();
        test_reset_mid();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Architectural register file; the write end of the write-back interface driven by wb_stage.
- Accepts one write per cycle: enable, 4-bit address, 32-bit data.
- Serves three combinational read ports to the decode stage: Rn, Rm, and the store-data/shift register.
- R0 is hardwired to zero. Same-cycle write-to-read bypass removes the WB→ID structural hazard.

Parameters:
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 4, register address width
- NUM_REGS, 16, number of architectural registers (must equal 2**ADDR_WIDTH)

Ports:
- clk  input  1  system clock; rising edge active
- reset  input  1  asynchronous, active-high reset
- enable  input  1  global stall gate; writes are ignored when low
- reg_write_en_in_wb  input  1  write request from wb_stage
- write_reg_addr_in_wb  input  ADDR_WIDTH  destination register
- write_data_in_wb  input  DATA_WIDTH  write-back data
- read_addr1_in_id  input  ADDR_WIDTH  Rn address
- read_addr2_in_id  input  ADDR_WIDTH  Rm address
- read_addr3_in_id  input  ADDR_WIDTH  Rd/Rs address (store data, register shift)
- read_data1_out_id  output  DATA_WIDTH  Rn value
- read_data2_out_id  output  DATA_WIDTH  Rm value
- read_data3_out_id  output  DATA_WIDTH  Rd/Rs value
- write_count_out  output  16  number of committed writes (debug)

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- While reset is high:
  - all NUM_REGS entries are 0;
  - write_count_out is 0;
  - every read port returns 0.
- Deassertion is taken on the next clk edge; no write commits on the edge coincident with reset.
- Commit condition: a write commits at the rising edge when enable = 1, reg_write_en_in_wb = 1 and write_reg_addr_in_wb != 0.
  - On commit, the entry takes write_data_in_wb.
  - On commit, write_count_out increments by 1 and wraps from 16'hFFFF to 0.
- Non-commit cases:
  - Writes to R0 never commit and do not increment the counter.
  - enable = 0 holds all state (array and counter).
  - reg_write_en_in_wb = 0 holds all state, regardless of the other write inputs.
- Reads are combinational with zero latency. For each port k, in priority order:
  1. read_addrk = 0 → 0.
  2. A commit is pending this cycle (condition above) and write_reg_addr_in_wb = read_addrk → write_data_in_wb (bypass).
  3. Otherwise → stored entry.
- Bypass requires the full commit condition: no bypass when enable = 0 or the address is 0.
- All three ports may address the same register concurrently; all return identical values.
- Reset asserted mid-write: the array is cleared immediately and the in-flight write is lost; reads return 0 until reset is deasserted.
- Widths: no truncation or extension; data passes bit-exact.

Decomposition:
- Shared package (cpu_pkg), holding:
  - DATA_WIDTH and ADDR_WIDTH constants;
  - REG_ZERO = 4'd0;
  - named register constants REG_SP = 4'd13, REG_LR = 4'd14, REG_PC = 4'd15 (no special behaviour here).
- One sub-module, rf_read_port, instantiated three times.
  - Inputs: address, array output vector, write-back bypass signals.
  - Implements the R0 / bypass / array priority mux.

Test Plan:
- Reset: assert reset mid-simulation after writing R1 = 32'h11223344 → all three read ports return 0 immediately; write_count_out = 0.
- Write then read: write R1 = 32'd100 (en = 1, enable = 1), next cycle read_addr1 = 1 → read_data1 = 32'd100; write_count_out = 1.
- Bypass: in the same cycle, write R2 = 32'hFACEB00C and read_addr2 = read_addr3 = 2 → both ports return 32'hFACEB00C before the edge; both still hold it after the edge.
- R0 hardwired: write R0 = 32'h11223344 with en = 1 → read_addr1 = 0 returns 0 both in the write cycle and after it; write_count_out unchanged.
- Write disable and stall:
  - reg_write_en_in_wb = 0 with R3 addressed and data 32'd50 → R3 keeps its prior value 0 and there is no bypass.
  - Repeat with en = 1, enable = 0 → same result; counter unchanged.
- Counter and full sweep: write Rk = k*32'h01010101 for k = 1..15, then read all → each value matches, R0 = 0, write_count_out = 15.
